// File: rtl/urv_decode_sb.sv
// urv_decode_sb - uRV decode stage with a parametrised latency scoreboard.
// Decodes RV32I(+M) words from fetch into registered execute-1 controls and
// inserts exactly as many bubbles as an in-flight producer's latency needs.
// Optional feature macro: URV_DECODE_DIV_EN (DIV/DIVU/REM/REMU decode as valid
// divider operations instead of undefined instructions).
// x_rd_source_o encoding: 0 ALU, 1 SHIFTER, 2 MULTIPLY, 3 CSR, 4 DIVIDE.
module urv_decode_sb #(
  parameter int LOAD_LAT   = 2,
  parameter int SHIFT_LAT  = 2,
  parameter int MUL_LAT    = 2,
  parameter int DIV_LAT    = 34,
  parameter int SB_ENTRIES = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        d_stall_i,
  input  logic        d_kill_i,
  output logic        d_stall_req_o,
  input  logic [31:0] f_ir_i,
  input  logic [31:0] f_pc_i,
  input  logic        f_valid_i,
  output logic [4:0]  rf_rs1_o,
  output logic [4:0]  rf_rs2_o,
  output logic        x_valid_o,
  output logic [31:0] x_pc_o,
  output logic [31:0] x_imm_o,
  output logic [4:0]  x_rs1_o,
  output logic [4:0]  x_rs2_o,
  output logic [4:0]  x_rd_o,
  output logic [4:0]  x_opcode_o,
  output logic [2:0]  x_fun_o,
  output logic        x_is_load_o,
  output logic        x_is_store_o,
  output logic        x_is_undef_o,
  output logic        x_is_div_o,
  output logic        x_rd_write_o,
  output logic [2:0]  x_rd_source_o
);

  // Opcodes as ir[6:2]
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_FENCE  = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  localparam logic [2:0] FUN_ADD = 3'b000;

  localparam logic [2:0] RD_SOURCE_ALU      = 3'd0;
  localparam logic [2:0] RD_SOURCE_SHIFTER  = 3'd1;
  localparam logic [2:0] RD_SOURCE_MULTIPLY = 3'd2;
  localparam logic [2:0] RD_SOURCE_CSR      = 3'd3;
  localparam logic [2:0] RD_SOURCE_DIVIDE   = 3'd4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

`ifdef URV_DECODE_DIV_EN
  localparam int MAX_LAT = max2(max2(LOAD_LAT, SHIFT_LAT), max2(MUL_LAT, DIV_LAT));
`else
  localparam int MAX_LAT = max2(max2(LOAD_LAT, SHIFT_LAT), MUL_LAT);
`endif
  localparam int CNT_W = $clog2(MAX_LAT) + 1;

  // Countdown start values: an entry stays busy for L-1 edges after issue
  localparam logic [CNT_W-1:0] LOAD_INIT  = CNT_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] SHIFT_INIT = CNT_W'(SHIFT_LAT - 1);
  localparam logic [CNT_W-1:0] MUL_INIT   = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_INIT   = CNT_W'(DIV_LAT - 1);

  // Raw fields of the word in D
  logic [4:0] d_opc, d_rs1, d_rs2, d_rd;
  logic [2:0] d_fun;
  assign d_opc = f_ir_i[6:2];
  assign d_rs1 = f_ir_i[19:15];
  assign d_rs2 = f_ir_i[24:20];
  assign d_rd  = f_ir_i[11:7];
  assign d_fun = f_ir_i[14:12];

  assign rf_rs1_o = d_rs1;
  assign rf_rs2_o = d_rs2;

  // Instruction classes
  logic d_is_m, d_div_enc, d_is_div, d_is_mul, d_is_shift;
  assign d_is_m     = (d_opc == OPC_OP) && f_ir_i[25];
  assign d_div_enc  = d_is_m && d_fun[2];
  assign d_is_mul   = d_is_m && !d_fun[2];
  assign d_is_shift = ((d_opc == OPC_OP) || (d_opc == OPC_OP_IMM)) && !d_is_m &&
                      ((d_fun == 3'b001) || (d_fun == 3'b101));
`ifdef URV_DECODE_DIV_EN
  assign d_is_div = d_div_enc;
`else
  assign d_is_div = 1'b0;
`endif

  logic [31:0]      d_imm;
  logic [2:0]       d_fun_x;
  logic [2:0]       d_rd_source;
  logic             d_rd_write;
  logic             d_is_undef;
  logic             d_known;
  logic             d_multi;
  logic [CNT_W-1:0] d_cnt_init;

  // Field decode: immediate, fun, rd write enable, result source, latency class
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    d_imm       = {{20{f_ir_i[31]}}, f_ir_i[31:20]};
    d_fun_x     = d_fun;
    d_rd_source = RD_SOURCE_ALU;
    d_rd_write  = 1'b0;
    d_known     = 1'b1;
    d_multi     = 1'b0;
    d_cnt_init  = '0;

    case (d_opc)
      OPC_STORE:  d_imm = {{20{f_ir_i[31]}}, f_ir_i[31:25], f_ir_i[11:7]};
      OPC_BRANCH: d_imm = {{19{f_ir_i[31]}}, f_ir_i[31], f_ir_i[7], f_ir_i[30:25],
                           f_ir_i[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: d_imm = {f_ir_i[31:12], 12'b0};
      OPC_JAL:    d_imm = {{11{f_ir_i[31]}}, f_ir_i[31], f_ir_i[19:12], f_ir_i[20],
                           f_ir_i[30:21], 1'b0};
      default:    d_imm = {{20{f_ir_i[31]}}, f_ir_i[31:20]};
    endcase

    case (d_opc)
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: d_fun_x = FUN_ADD;
      default: d_fun_x = d_fun;
    endcase

    case (d_opc)
      OPC_OP, OPC_OP_IMM, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_LOAD:
        d_rd_write = (d_rd != 5'd0);
      OPC_SYSTEM:
        d_rd_write = (d_fun != 3'b000) && (d_rd != 5'd0);
      default:
        d_rd_write = 1'b0;
    endcase

    case (d_opc)
      OPC_LOAD, OPC_FENCE, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: d_known = 1'b1;
      default: d_known = 1'b0;
    endcase

    if (d_is_shift)       d_rd_source = RD_SOURCE_SHIFTER;
    else if (d_is_mul)    d_rd_source = RD_SOURCE_MULTIPLY;
    else if (d_is_div)    d_rd_source = RD_SOURCE_DIVIDE;
    else if (d_opc == OPC_SYSTEM) d_rd_source = RD_SOURCE_CSR;

    // Divide encodings without the divider are undefined and never write rd
    if (d_is_undef) d_rd_write = 1'b0;

    if (d_rd_write) begin
      if (d_opc == OPC_LOAD && LOAD_LAT > 1) begin
        d_multi = 1'b1; d_cnt_init = LOAD_INIT;
      end else if (d_is_shift && SHIFT_LAT > 1) begin
        d_multi = 1'b1; d_cnt_init = SHIFT_INIT;
      end else if (d_is_mul && MUL_LAT > 1) begin
        d_multi = 1'b1; d_cnt_init = MUL_INIT;
      end else if (d_is_div && DIV_LAT > 1) begin
        d_multi = 1'b1; d_cnt_init = DIV_INIT;
      end
    end
  end

  assign d_is_undef = !d_known || (f_ir_i[1:0] != 2'b11) || (d_div_enc && !d_is_div);

  // Scoreboard state
  logic [SB_ENTRIES-1:0] sb_busy;
  logic [4:0]            sb_rd  [SB_ENTRIES];
  logic [CNT_W-1:0]      sb_cnt [SB_ENTRIES];

  logic                  sb_raw, sb_full, hazard, take, alloc, alloc_found;
  logic [SB_ENTRIES-1:0] alloc_sel;

  // Source-operand match against every busy entry holding a non-zero rd
  always_comb begin
    sb_raw = 1'b0;
    for (int i = 0; i < SB_ENTRIES; i++) begin
      if (sb_busy[i] && (sb_rd[i] != 5'd0) &&
          ((sb_rd[i] == d_rs1) || (sb_rd[i] == d_rs2)))
        sb_raw = 1'b1;
    end
  end

  assign sb_full       = &sb_busy;
  assign hazard        = f_valid_i && !d_kill_i && (sb_raw || (sb_full && d_multi));
  assign take          = f_valid_i && !d_kill_i && !hazard;
  assign alloc         = take && d_multi && !d_stall_i;
  assign d_stall_req_o = hazard;

  // Lowest free entry; an entry freeing on this edge is still busy here, so
  // it only becomes allocatable on the following cycle
  always_comb begin
    alloc_sel   = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < SB_ENTRIES; i++) begin
      if (!sb_busy[i] && !alloc_found) begin
        alloc_sel[i] = alloc;
        alloc_found  = 1'b1;
      end
    end
  end

  // Scoreboard: allocate on issue, count down busy entries, all frozen by d_stall_i
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: these arrays are a handful of flops, not a RAM; they must be
      // reset because a stale busy bit would stall decode forever.
      for (int i = 0; i < SB_ENTRIES; i++) begin
        sb_busy[i] <= 1'b0;
        sb_rd[i]   <= 5'd0;
        sb_cnt[i]  <= '0;
      end
    end else if (!d_stall_i) begin
      for (int i = 0; i < SB_ENTRIES; i++) begin
        if (alloc_sel[i]) begin
          sb_busy[i] <= 1'b1;
          sb_rd[i]   <= d_rd;
          sb_cnt[i]  <= d_cnt_init;
        end else if (sb_busy[i] && (sb_cnt[i] != '0)) begin
          sb_cnt[i] <= sb_cnt[i] - 1'b1;
          if (sb_cnt[i] == CNT_W'(1)) sb_busy[i] <= 1'b0;
        end
      end
    end
  end

  // D->X pipeline register; a hazard or kill loads a bubble
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n_i) begin
      x_valid_o     <= 1'b0;
      x_pc_o        <= '0;
      x_imm_o       <= '0;
      x_rs1_o       <= '0;
      x_rs2_o       <= '0;
      x_rd_o        <= '0;
      x_opcode_o    <= '0;
      x_fun_o       <= '0;
      x_is_load_o   <= 1'b0;
      x_is_store_o  <= 1'b0;
      x_is_undef_o  <= 1'b0;
      x_is_div_o    <= 1'b0;
      x_rd_write_o  <= 1'b0;
      x_rd_source_o <= '0;
    end else if (!d_stall_i) begin
      x_valid_o     <= take;
      x_pc_o        <= f_pc_i;
      x_imm_o       <= d_imm;
      x_rs1_o       <= d_rs1;
      x_rs2_o       <= d_rs2;
      x_rd_o        <= d_rd;
      x_opcode_o    <= d_opc;
      x_fun_o       <= d_fun_x;
      x_is_load_o   <= take && (d_opc == OPC_LOAD);
      x_is_store_o  <= take && (d_opc == OPC_STORE);
      x_is_undef_o  <= d_is_undef;
      x_is_div_o    <= take && d_is_div;
      x_rd_write_o  <= take && d_rd_write;
      x_rd_source_o <= d_rd_source;
    end
  end

endmodule

// File: tb/tb_urv_decode_sb.sv
// tb_urv_decode_sb - directed bench for urv_decode_sb.
// DUT a uses default parameters; DUT b uses LOAD_LAT=4, MUL_LAT=4, SB_ENTRIES=2.
// Both share the stimulus; each scenario checks the instance it targets.
module tb_urv_decode_sb;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        d_stall_i = 1'b0;
  logic        d_kill_i = 1'b0;
  logic [31:0] f_ir_i = '0;
  logic [31:0] f_pc_i = '0;
  logic        f_valid_i = 1'b0;

  logic        a_stall, a_x_valid, a_x_is_load, a_x_is_store, a_x_is_undef, a_x_is_div, a_x_rd_write;
  logic [4:0]  a_rf_rs1, a_rf_rs2, a_x_rs1, a_x_rs2, a_x_rd, a_x_opcode;
  logic [31:0] a_x_pc, a_x_imm;
  logic [2:0]  a_x_fun, a_x_rd_source;

  logic        b_stall, b_x_valid, b_x_is_load, b_x_is_store, b_x_is_undef, b_x_is_div, b_x_rd_write;
  logic [4:0]  b_rf_rs1, b_rf_rs2, b_x_rs1, b_x_rs2, b_x_rd, b_x_opcode;
  logic [31:0] b_x_pc, b_x_imm;
  logic [2:0]  b_x_fun, b_x_rd_source;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  urv_decode_sb u_dut_a (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .d_stall_i(d_stall_i), .d_kill_i(d_kill_i),
    .d_stall_req_o(a_stall), .f_ir_i(f_ir_i), .f_pc_i(f_pc_i), .f_valid_i(f_valid_i),
    .rf_rs1_o(a_rf_rs1), .rf_rs2_o(a_rf_rs2), .x_valid_o(a_x_valid), .x_pc_o(a_x_pc),
    .x_imm_o(a_x_imm), .x_rs1_o(a_x_rs1), .x_rs2_o(a_x_rs2), .x_rd_o(a_x_rd),
    .x_opcode_o(a_x_opcode), .x_fun_o(a_x_fun), .x_is_load_o(a_x_is_load),
    .x_is_store_o(a_x_is_store), .x_is_undef_o(a_x_is_undef), .x_is_div_o(a_x_is_div),
    .x_rd_write_o(a_x_rd_write), .x_rd_source_o(a_x_rd_source)
  );

  urv_decode_sb #(.LOAD_LAT(4), .MUL_LAT(4), .SB_ENTRIES(2)) u_dut_b (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .d_stall_i(d_stall_i), .d_kill_i(d_kill_i),
    .d_stall_req_o(b_stall), .f_ir_i(f_ir_i), .f_pc_i(f_pc_i), .f_valid_i(f_valid_i),
    .rf_rs1_o(b_rf_rs1), .rf_rs2_o(b_rf_rs2), .x_valid_o(b_x_valid), .x_pc_o(b_x_pc),
    .x_imm_o(b_x_imm), .x_rs1_o(b_x_rs1), .x_rs2_o(b_x_rs2), .x_rd_o(b_x_rd),
    .x_opcode_o(b_x_opcode), .x_fun_o(b_x_fun), .x_is_load_o(b_x_is_load),
    .x_is_store_o(b_x_is_store), .x_is_undef_o(b_x_is_undef), .x_is_div_o(b_x_is_div),
    .x_rd_write_o(b_x_rd_write), .x_rd_source_o(b_x_rd_source)
  );

  // Fixed instruction words
  localparam logic [31:0] LW_X5 = 32'h0000A283;  // lw x5,0(x1)
  localparam logic [31:0] LW_X0 = 32'h0000A003;  // lw x0,0(x1)
  localparam logic [31:0] LW_X8 = 32'h0000A403;  // lw x8,0(x1)

  // R-type encoder (OP opcode) for stimulus words
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  // Present a word in D; hold it while the selected instance requests a stall.
  // Returns with the word loaded into X, and reports the number of bubbles.
  task automatic feed(input logic [31:0] ir, input logic [31:0] pc, input bit use_b,
                      output int stalls);
    bit done = 1'b0;
    bit st;
    stalls = 0;
    f_valid_i = 1'b1;
    f_ir_i = ir;
    f_pc_i = pc;
    for (int n = 0; n < 64 && !done; n++) begin
      #1;
      st = use_b ? b_stall : a_stall;
      @(posedge clk_i); #1;
      if (st) stalls++;
      else done = 1'b1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL feed_timeout ir=%08h still stalled after 64 cycles", ir);
    end
    f_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    f_valid_i = 1'b0;
    d_kill_i = 1'b0;
    d_stall_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    f_valid_i = 1'b1;
    f_ir_i = LW_X5;
    f_pc_i = 32'h0000_0040;
    repeat (2) @(posedge clk_i);
    #1;
    checks++; if (a_x_valid !== 1'b0) begin failures++; $display("FAIL reset_x_valid got=%b exp=0", a_x_valid); end
    checks++; if (a_x_pc !== 32'h0) begin failures++; $display("FAIL reset_x_pc got=%h exp=0", a_x_pc); end
    checks++; if (a_x_imm !== 32'h0) begin failures++; $display("FAIL reset_x_imm got=%h exp=0", a_x_imm); end
    checks++; if (a_x_rd_write !== 1'b0) begin failures++; $display("FAIL reset_rd_write got=%b exp=0", a_x_rd_write); end
    checks++; if (a_x_is_load !== 1'b0) begin failures++; $display("FAIL reset_is_load got=%b exp=0", a_x_is_load); end
    checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL reset_stall_req got=%b exp=0", a_stall); end
    checks++; if (b_x_valid !== 1'b0) begin failures++; $display("FAIL reset_b_x_valid got=%b exp=0", b_x_valid); end
    f_valid_i = 1'b0;
    rst_n_i = 1'b1;
  endtask

  typedef struct {
    logic [31:0] ir;
    logic [31:0] imm;
    logic [2:0]  fun;
    logic        rd_write;
    logic [2:0]  src;
    logic [4:0]  opc;
    logic        store;
  } dec_vec_t;

  task automatic test_decode();
    dec_vec_t v [9];
    int s;
    v[0] = '{32'h123451B7, 32'h12345000, 3'd0, 1'b1, 3'd0, 5'h0D, 1'b0};  // lui x3,0x12345
    v[1] = '{32'hFF9FF0EF, 32'hFFFFFFF8, 3'd0, 1'b1, 3'd0, 5'h1B, 1'b0};  // jal x1,-8
    v[2] = '{32'h0020A423, 32'h00000008, 3'd2, 1'b0, 3'd0, 5'h08, 1'b1};  // sw x2,8(x1)
    v[3] = '{32'hFE208EE3, 32'hFFFFFFFC, 3'd0, 1'b0, 3'd0, 5'h18, 1'b0};  // beq x1,x2,-4
    v[4] = '{32'hFFF08213, 32'hFFFFFFFF, 3'd0, 1'b1, 3'd0, 5'h04, 1'b0};  // addi x4,x1,-1
    v[5] = '{32'h300022F3, 32'h00000300, 3'd2, 1'b1, 3'd3, 5'h1C, 1'b0};  // csrrs x5,0x300,x0
    v[6] = '{32'h00000073, 32'h00000000, 3'd0, 1'b0, 3'd3, 5'h1C, 1'b0};  // ecall
    v[7] = '{32'h00001517, 32'h00001000, 3'd0, 1'b1, 3'd0, 5'h05, 1'b0};  // auipc x10,1
    v[8] = '{32'h40435393, 32'h00000404, 3'd5, 1'b1, 3'd1, 5'h04, 1'b0};  // srai x7,x6,4
    do_reset();
    for (int i = 0; i < 9; i++) begin
      feed(v[i].ir, 32'h1000 + 32'(i * 4), 1'b0, s);
      checks++; if (a_x_valid !== 1'b1) begin failures++; $display("FAIL dec%0d_valid got=%b exp=1", i, a_x_valid); end
      checks++; if (a_x_imm !== v[i].imm) begin failures++; $display("FAIL dec%0d_imm got=%h exp=%h", i, a_x_imm, v[i].imm); end
      checks++; if (a_x_fun !== v[i].fun) begin failures++; $display("FAIL dec%0d_fun got=%0d exp=%0d", i, a_x_fun, v[i].fun); end
      checks++; if (a_x_rd_write !== v[i].rd_write) begin failures++; $display("FAIL dec%0d_rd_write got=%b exp=%b", i, a_x_rd_write, v[i].rd_write); end
      checks++; if (a_x_rd_source !== v[i].src) begin failures++; $display("FAIL dec%0d_rd_source got=%0d exp=%0d", i, a_x_rd_source, v[i].src); end
      checks++; if (a_x_opcode !== v[i].opc) begin failures++; $display("FAIL dec%0d_opcode got=%h exp=%h", i, a_x_opcode, v[i].opc); end
      checks++; if (a_x_is_store !== v[i].store) begin failures++; $display("FAIL dec%0d_is_store got=%b exp=%b", i, a_x_is_store, v[i].store); end
    end
  endtask

  // lw x5 then dependent add with LOAD_LAT=2: exactly one bubble
  task automatic test_load_use();
    int s;
    do_reset();
    feed(LW_X5, 32'h100, 1'b0, s);
    checks++; if (a_x_is_load !== 1'b1 || a_x_rd !== 5'd5) begin failures++; $display("FAIL lu_load_x got_is_load=%b rd=%0d exp=1,5", a_x_is_load, a_x_rd); end
    f_valid_i = 1'b1; f_ir_i = enc_r(7'd0, 5'd2, 5'd5, 3'd0, 5'd6); f_pc_i = 32'h104;
    #1;
    checks++; if (a_stall !== 1'b1) begin failures++; $display("FAIL lu_stall_req got=%b exp=1", a_stall); end
    checks++; if (a_rf_rs1 !== 5'd5 || a_rf_rs2 !== 5'd2) begin failures++; $display("FAIL lu_rf_addr got=%0d,%0d exp=5,2", a_rf_rs1, a_rf_rs2); end
    @(posedge clk_i); #1;
    checks++; if (a_x_valid !== 1'b0 || a_x_is_load !== 1'b0) begin failures++; $display("FAIL lu_bubble got_valid=%b is_load=%b exp=0,0", a_x_valid, a_x_is_load); end
    checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL lu_stall_release got=%b exp=0", a_stall); end
    @(posedge clk_i); #1;
    checks++; if (a_x_valid !== 1'b1 || a_x_pc !== 32'h104) begin failures++; $display("FAIL lu_add_issue got_valid=%b pc=%h exp=1,104", a_x_valid, a_x_pc); end
    f_valid_i = 1'b0;
    // shift producer with SHIFT_LAT=2 -> one bubble for its consumer
    feed(32'h40435393, 32'h108, 1'b0, s);
    feed(enc_r(7'd0, 5'd0, 5'd7, 3'd0, 5'd9), 32'h10C, 1'b0, s);
    checks++; if (s != 1) begin failures++; $display("FAIL lu_shift_bubbles got=%0d exp=1", s); end
  endtask

  // LOAD_LAT=4 instance: dependent consumer sees 3 bubbles, independent none
  task automatic test_load_lat4();
    int s;
    do_reset();
    feed(LW_X5, 32'h200, 1'b1, s);
    feed(enc_r(7'd0, 5'd2, 5'd5, 3'd0, 5'd6), 32'h204, 1'b1, s);
    checks++; if (s != 3) begin failures++; $display("FAIL lat4_dep_bubbles got=%0d exp=3", s); end
    checks++; if (b_x_valid !== 1'b1 || b_x_pc !== 32'h204) begin failures++; $display("FAIL lat4_dep_issue got_valid=%b pc=%h exp=1,204", b_x_valid, b_x_pc); end
    feed(LW_X5, 32'h208, 1'b1, s);
    feed(enc_r(7'd0, 5'd7, 5'd4, 3'd0, 5'd3), 32'h20C, 1'b1, s);
    checks++; if (s != 0) begin failures++; $display("FAIL lat4_indep_bubbles got=%0d exp=0", s); end
  endtask

  // d_stall_i freezes counters and X while the consumer waits in D
  task automatic test_stall_freeze();
    int s;
    do_reset();
    feed(LW_X5, 32'h300, 1'b0, s);
    f_valid_i = 1'b1; f_ir_i = enc_r(7'd0, 5'd2, 5'd5, 3'd0, 5'd6); f_pc_i = 32'h304;
    d_stall_i = 1'b1;
    repeat (5) begin @(posedge clk_i); #1; end
    checks++; if (a_x_valid !== 1'b1 || a_x_pc !== 32'h300) begin failures++; $display("FAIL frz_x_hold got_valid=%b pc=%h exp=1,300", a_x_valid, a_x_pc); end
    checks++; if (a_stall !== 1'b1) begin failures++; $display("FAIL frz_stall_req got=%b exp=1", a_stall); end
    d_stall_i = 1'b0;
    feed(enc_r(7'd0, 5'd2, 5'd5, 3'd0, 5'd6), 32'h304, 1'b0, s);
    checks++; if (s != 1) begin failures++; $display("FAIL frz_bubbles got=%0d exp=1", s); end
    checks++; if (a_x_pc !== 32'h304) begin failures++; $display("FAIL frz_add_pc got=%h exp=304", a_x_pc); end
  endtask

  // Two-entry scoreboard, MUL_LAT=4: third independent mul waits for a free entry
  task automatic test_sb_full();
    int s1, s2, s3;
    do_reset();
    feed(enc_r(7'd1, 5'd2, 5'd1, 3'd0, 5'd10), 32'h400, 1'b1, s1);
    feed(enc_r(7'd1, 5'd4, 5'd3, 3'd0, 5'd11), 32'h404, 1'b1, s2);
    feed(enc_r(7'd1, 5'd6, 5'd5, 3'd0, 5'd12), 32'h408, 1'b1, s3);
    checks++; if (s1 != 0 || s2 != 0) begin failures++; $display("FAIL full_first_two got=%0d,%0d exp=0,0", s1, s2); end
    checks++; if (s3 != 2) begin failures++; $display("FAIL full_third_bubbles got=%0d exp=2", s3); end
    checks++; if (b_x_rd_source !== 3'd2 || b_x_rd !== 5'd12) begin failures++; $display("FAIL full_mul_x got_src=%0d rd=%0d exp=2,12", b_x_rd_source, b_x_rd); end
  endtask

  // rd=x0 never interlocks; kill beats hazard and does not allocate
  task automatic test_x0_and_kill();
    int s;
    do_reset();
    feed(LW_X0, 32'h500, 1'b0, s);
    checks++; if (a_x_rd_write !== 1'b0) begin failures++; $display("FAIL x0_rd_write got=%b exp=0", a_x_rd_write); end
    feed(enc_r(7'd0, 5'd0, 5'd0, 3'd0, 5'd1), 32'h504, 1'b0, s);
    checks++; if (s != 0) begin failures++; $display("FAIL x0_bubbles got=%0d exp=0", s); end
    feed(LW_X5, 32'h508, 1'b0, s);
    f_valid_i = 1'b1; f_ir_i = enc_r(7'd0, 5'd2, 5'd5, 3'd0, 5'd6); f_pc_i = 32'h50C;
    d_kill_i = 1'b1;
    #1;
    checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL kill_stall_req got=%b exp=0", a_stall); end
    @(posedge clk_i); #1;
    checks++; if (a_x_valid !== 1'b0) begin failures++; $display("FAIL kill_x_valid got=%b exp=0", a_x_valid); end
    d_kill_i = 1'b0;
    feed(enc_r(7'd0, 5'd5, 5'd5, 3'd0, 5'd7), 32'h510, 1'b0, s);
    checks++; if (s != 0) begin failures++; $display("FAIL kill_next_bubbles got=%0d exp=0", s); end
    // killed producer must not allocate
    f_valid_i = 1'b1; f_ir_i = LW_X8; f_pc_i = 32'h514; d_kill_i = 1'b1;
    @(posedge clk_i); #1;
    d_kill_i = 1'b0;
    feed(enc_r(7'd0, 5'd8, 5'd8, 3'd0, 5'd9), 32'h518, 1'b0, s);
    checks++; if (s != 0) begin failures++; $display("FAIL kill_no_alloc_bubbles got=%0d exp=0", s); end
  endtask

  // div x9,x1,x2 then add x3,x9,x9
  task automatic test_div();
    int s;
    do_reset();
    feed(enc_r(7'd1, 5'd2, 5'd1, 3'd4, 5'd9), 32'h600, 1'b0, s);
    checks++; if (a_x_valid !== 1'b1) begin failures++; $display("FAIL div_valid got=%b exp=1", a_x_valid); end
`ifdef URV_DECODE_DIV_EN
    checks++; if (a_x_is_div !== 1'b1 || a_x_is_undef !== 1'b0) begin failures++; $display("FAIL div_flags got_div=%b undef=%b exp=1,0", a_x_is_div, a_x_is_undef); end
    checks++; if (a_x_rd_source !== 3'd4 || a_x_rd_write !== 1'b1) begin failures++; $display("FAIL div_src got_src=%0d rdw=%b exp=4,1", a_x_rd_source, a_x_rd_write); end
    feed(enc_r(7'd0, 5'd9, 5'd9, 3'd0, 5'd3), 32'h604, 1'b0, s);
    checks++; if (s != 33) begin failures++; $display("FAIL div_bubbles got=%0d exp=33", s); end
`else
    checks++; if (a_x_is_undef !== 1'b1 || a_x_is_div !== 1'b0) begin failures++; $display("FAIL div_flags got_undef=%b div=%b exp=1,0", a_x_is_undef, a_x_is_div); end
    checks++; if (a_x_rd_write !== 1'b0) begin failures++; $display("FAIL div_rd_write got=%b exp=0", a_x_rd_write); end
    feed(enc_r(7'd0, 5'd9, 5'd9, 3'd0, 5'd3), 32'h604, 1'b0, s);
    checks++; if (s != 0) begin failures++; $display("FAIL div_bubbles got=%0d exp=0", s); end
`endif
  endtask

  // Asynchronous reset with a pending hazard clears it immediately
  task automatic test_reset_mid();
    int s;
    do_reset();
    feed(LW_X5, 32'h700, 1'b0, s);
    f_valid_i = 1'b1; f_ir_i = enc_r(7'd0, 5'd2, 5'd5, 3'd0, 5'd6); f_pc_i = 32'h704;
    #1;
    checks++; if (a_stall !== 1'b1) begin failures++; $display("FAIL rmid_pre_stall got=%b exp=1", a_stall); end
    rst_n_i = 1'b0;
    #1;
    checks++; if (a_stall !== 1'b0 || a_x_valid !== 1'b0) begin failures++; $display("FAIL rmid_cleared got_stall=%b valid=%b exp=0,0", a_stall, a_x_valid); end
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    feed(enc_r(7'd0, 5'd2, 5'd5, 3'd0, 5'd6), 32'h704, 1'b0, s);
    checks++; if (s != 0 || a_x_valid !== 1'b1) begin failures++; $display("FAIL rmid_after got_bubbles=%0d valid=%b exp=0,1", s, a_x_valid); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_load_use();
    test_load_lat4();
    test_stall_freeze();
    test_sb_full();
    test_x0_and_kill();
    test_div();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
